// File: rtl/apb_to_tcdm_bridge_pkg.sv
// apb_to_tcdm_bridge_pkg: shared types and constants for the APB-to-TCDM bridge.
package apb_tcdm_bridge_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    localparam logic [BUS_DW/8-1:0] READ_BE_ALL = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DONE
    } state_e;

    // Transfer captured in the APB setup phase; addr is already word-aligned.
    typedef struct packed {
        logic [BUS_AW-1:0]   addr;
        logic [BUS_DW-1:0]   wdata;
        logic [BUS_DW/8-1:0] be;
        logic                write;
    } xfer_t;

endpackage

// File: rtl/apb_to_tcdm_bridge_if.sv
// apb_to_tcdm_bridge_if: APB4 completer side plus TCDM master side of the bridge.
// Signal names carry the bridge's point of view (_i into the bridge, _o out of it).
// slave modport: the bridge; master modport: the environment (APB requester + TCDM target).
interface apb_to_tcdm_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   paddr_i;
    logic                    psel_i;
    logic                    penable_i;
    logic                    pwrite_i;
    logic [DATA_WIDTH-1:0]   pwdata_i;
    logic [DATA_WIDTH/8-1:0] pstrb_i;
    logic [DATA_WIDTH-1:0]   prdata_o;
    logic                    pready_o;
    logic                    pslverr_o;

    logic                    tcdm_req_o;
    logic [ADDR_WIDTH-1:0]   tcdm_add_o;
    logic                    tcdm_wen_o;
    logic [DATA_WIDTH-1:0]   tcdm_wdata_o;
    logic [DATA_WIDTH/8-1:0] tcdm_be_o;
    logic                    tcdm_gnt_i;
    logic                    tcdm_r_valid_i;
    logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i;
    logic                    tcdm_r_opc_i;

    modport slave (
        input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o,
        output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i, tcdm_r_opc_i
    );

    modport master (
        output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o,
        input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i, tcdm_r_opc_i
    );

endinterface

// File: rtl/apb_to_tcdm_bridge.sv
// apb_to_tcdm_bridge: APB4 completer turning each transfer into one 32-bit TCDM request.
// Ports: clk_i, rst_i (sync, active-high), bus (apb_to_tcdm_bridge_if.slave: APB in, TCDM out).
// Every output comes straight from a register; one transfer is outstanding at a time.
module apb_to_tcdm_bridge
    import apb_tcdm_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = BUS_AW,
    parameter int unsigned           DATA_WIDTH     = BUS_DW,
    parameter logic [ADDR_WIDTH-1:0] WIN_START      = 32'h1C00_0000,
    parameter logic [ADDR_WIDTH-1:0] WIN_END        = 32'h1C08_0000,
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    apb_to_tcdm_bridge_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                state_q, state_d;
    xfer_t                 x_q, x_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic setup, in_win, timed_out;

    assign setup     = bus.psel_i && !bus.penable_i;
    assign in_win    = (bus.paddr_i >= WIN_START) && (bus.paddr_i < WIN_END);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            x_q       <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // APB response registers default to 0 and are only loaded on the way into DONE,
    // so the pready pulse is exactly one cycle wide.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    x_d.addr  = {bus.paddr_i[ADDR_WIDTH-1:2], 2'b00};
                    x_d.wdata = bus.pwdata_i;
                    x_d.be    = bus.pwrite_i ? bus.pstrb_i : READ_BE_ALL;
                    x_d.write = bus.pwrite_i;
                    cnt_d     = '0;
                    state_d   = in_win ? ISSUE : DONE;
                    req_d     = in_win;
                    pready_d  = !in_win;
                    pslverr_d = !in_win;
                end
            end
            ISSUE: begin
                if (bus.tcdm_gnt_i) begin
                    state_d = WAIT_RESP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d   = DONE;
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RESP: begin
                if (bus.tcdm_r_valid_i) begin
                    state_d   = DONE;
                    pready_d  = 1'b1;
                    pslverr_d = bus.tcdm_r_opc_i;
                    prdata_d  = x_q.write ? '0 : bus.tcdm_r_rdata_i;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.tcdm_req_o   = req_q;
    assign bus.tcdm_add_o   = x_q.addr;
    assign bus.tcdm_wen_o   = !x_q.write;
    assign bus.tcdm_wdata_o = x_q.wdata;
    assign bus.tcdm_be_o    = x_q.be;
    assign bus.pready_o     = pready_q;
    assign bus.pslverr_o    = pslverr_q;
    assign bus.prdata_o     = prdata_q;

endmodule

// File: tb/tb_apb_to_tcdm_bridge.sv
// tb_apb_to_tcdm_bridge: directed bench for the bridge; a second instance with a short timeout.
module tb_apb_to_tcdm_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel_to;
    logic [31:0] paddr, pwdata, rdata;
    logic        psel, penable, pwrite, gnt, rvalid, opc;
    logic [3:0]  pstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb_to_tcdm_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bm ();
    apb_to_tcdm_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bt ();

    apb_to_tcdm_bridge dut (.clk_i(clk), .rst_i(rst), .bus(bm));
    apb_to_tcdm_bridge #(.TIMEOUT_CYCLES(4)) dut_to (.clk_i(clk), .rst_i(rst), .bus(bt));

    // sel_to routes APB/TCDM stimulus to one instance; the other sees an idle bus.
    assign bm.paddr_i        = paddr;
    assign bm.psel_i         = psel && !sel_to;
    assign bm.penable_i      = penable;
    assign bm.pwrite_i       = pwrite;
    assign bm.pwdata_i       = pwdata;
    assign bm.pstrb_i        = pstrb;
    assign bm.tcdm_gnt_i     = gnt && !sel_to;
    assign bm.tcdm_r_valid_i = rvalid && !sel_to;
    assign bm.tcdm_r_rdata_i = rdata;
    assign bm.tcdm_r_opc_i   = opc;
    assign bt.paddr_i        = paddr;
    assign bt.psel_i         = psel && sel_to;
    assign bt.penable_i      = penable;
    assign bt.pwrite_i       = pwrite;
    assign bt.pwdata_i       = pwdata;
    assign bt.pstrb_i        = pstrb;
    assign bt.tcdm_gnt_i     = gnt && sel_to;
    assign bt.tcdm_r_valid_i = rvalid && sel_to;
    assign bt.tcdm_r_rdata_i = rdata;
    assign bt.tcdm_r_opc_i   = opc;

    logic        req, wen, pready, pslverr;
    logic [31:0] add, wdata, prdata;
    logic [3:0]  be;

    assign req     = sel_to ? bt.tcdm_req_o   : bm.tcdm_req_o;
    assign add     = sel_to ? bt.tcdm_add_o   : bm.tcdm_add_o;
    assign wen     = sel_to ? bt.tcdm_wen_o   : bm.tcdm_wen_o;
    assign wdata   = sel_to ? bt.tcdm_wdata_o : bm.tcdm_wdata_o;
    assign be      = sel_to ? bt.tcdm_be_o    : bm.tcdm_be_o;
    assign pready  = sel_to ? bt.pready_o     : bm.pready_o;
    assign pslverr = sel_to ? bt.pslverr_o    : bm.pslverr_o;
    assign prdata  = sel_to ? bt.prdata_o     : bm.prdata_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the setup phase for one cycle; returns in the first access-phase cycle.
    task automatic setup(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        psel    = 1'b1;
        penable = 1'b0;
        tick();
        penable = 1'b1;
    endtask

    task automatic idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel_to = 1'b0;
        paddr = '0; pwdata = '0; rdata = '0; pstrb = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; gnt = 1'b0; rvalid = 1'b0; opc = 1'b0;
        repeat (3) tick();
        check("rst_req", req, 0);
        check("rst_add", add, 0);
        check("rst_wen", wen, 1);
        check("rst_wdata", wdata, 0);
        check("rst_be", be, 0);
        check("rst_pready", pready, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_prdata", prdata, 0);
        rst = 1'b0;
        tick();

        // Read, gnt in first ISSUE cycle, r_valid one cycle later.
        setup(32'h1C00_0104, 1'b0, 32'h0, 4'h0);
        check("rd_req", req, 1);
        check("rd_add", add, 32'h1C00_0104);
        check("rd_wen", wen, 1);
        check("rd_be", be, 4'hF);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check("rd_req_drop", req, 0);
        check("rd_pready_early", pready, 0);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; opc = 1'b0;
        tick();
        rvalid = 1'b0;
        check("rd_pready", pready, 1);
        check("rd_prdata", prdata, 32'hCAFE_F00D);
        check("rd_pslverr", pslverr, 0);
        idle();
        tick();
        check("rd_pready_clr", pready, 0);
        check("rd_prdata_clr", prdata, 0);

        // Write with gnt delayed 5 cycles; a stray r_valid during ISSUE must be ignored.
        setup(32'h1C00_0203, 1'b1, 32'h1234_5678, 4'b0110);
        for (int i = 0; i < 6; i++) begin
            check("wr_req_hold", req, 1);
            check("wr_add", add, 32'h1C00_0200);
            if (i == 0) begin
                check("wr_be", be, 4'b0110);
                check("wr_wen", wen, 0);
                check("wr_wdata", wdata, 32'h1234_5678);
            end
            rvalid = (i == 2);
            rdata  = 32'hBAD0_BAD0;
            gnt    = (i == 5);
            tick();
        end
        gnt = 1'b0;
        check("wr_req_drop", req, 0);
        check("wr_pready_early", pready, 0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        check("wr_pready", pready, 1);
        check("wr_pslverr", pslverr, 0);
        check("wr_prdata", prdata, 0);
        idle();
        tick();
        check("wr_pready_clr", pready, 0);

        // Out-of-window read, then the exclusive window end.
        setup(32'h1A10_0000, 1'b0, 32'h0, 4'h0);
        check("oow_req", req, 0);
        check("oow_pready", pready, 1);
        check("oow_pslverr", pslverr, 1);
        check("oow_prdata", prdata, 0);
        idle();
        tick();
        check("oow_pready_clr", pready, 0);
        check("oow_pslverr_clr", pslverr, 0);
        setup(32'h1C08_0000, 1'b0, 32'h0, 4'h0);
        check("end_req", req, 0);
        check("end_pready", pready, 1);
        check("end_pslverr", pslverr, 1);
        idle();
        tick();

        // Grant timeout on the TIMEOUT_CYCLES=4 instance.
        sel_to = 1'b1;
        tick();
        setup(32'h1C00_0010, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check("to_req_hold", req, 1);
            tick();
        end
        check("to_req_drop", req, 0);
        check("to_pready", pready, 1);
        check("to_pslverr", pslverr, 1);
        check("to_prdata", prdata, 0);
        idle();
        tick();
        check("to_pready_clr", pready, 0);
        setup(32'h1C00_0000, 1'b0, 32'h0, 4'h0);
        check("to2_req", req, 1);
        check("to2_add", add, 32'h1C00_0000);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h1357_9BDF;
        tick();
        rvalid = 1'b0;
        check("to2_pready", pready, 1);
        check("to2_prdata", prdata, 32'h1357_9BDF);
        check("to2_pslverr", pslverr, 0);
        idle();
        tick();
        sel_to = 1'b0;
        tick();

        // Write answered with r_opc=1, then a back-to-back read.
        setup(32'h1C00_0040, 1'b1, 32'hA5A5_A5A5, 4'hF);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; opc = 1'b1; rdata = 32'h0;
        tick();
        rvalid = 1'b0; opc = 1'b0;
        check("opc_pready", pready, 1);
        check("opc_pslverr", pslverr, 1);
        tick();
        check("b2b_idle_pready", pready, 0);
        setup(32'h1C00_0044, 1'b0, 32'h0, 4'h0);
        check("b2b_req", req, 1);
        check("b2b_add", add, 32'h1C00_0044);
        check("b2b_wen", wen, 1);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h600D_F00D;
        tick();
        rvalid = 1'b0;
        check("b2b_pready", pready, 1);
        check("b2b_prdata", prdata, 32'h600D_F00D);
        check("b2b_pslverr", pslverr, 0);
        idle();
        tick();

        // Reset during WAIT_RESP followed by a stray r_valid.
        setup(32'h1C00_0100, 1'b1, 32'h7777_7777, 4'h3);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("mrst_req", req, 0);
        check("mrst_wen", wen, 1);
        check("mrst_add", add, 0);
        check("mrst_be", be, 0);
        check("mrst_pready", pready, 0);
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        rvalid = 1'b0;
        check("stray_pready", pready, 0);
        check("stray_req", req, 0);
        tick();
        check("stray_pready2", pready, 0);
        setup(32'h1C00_0108, 1'b0, 32'h0, 4'h0);
        check("post_req", req, 1);
        check("post_add", add, 32'h1C00_0108);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h2468_ACE0;
        tick();
        rvalid = 1'b0;
        check("post_pready", pready, 1);
        check("post_prdata", prdata, 32'h2468_ACE0);
        check("post_pslverr", pslverr, 0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
